// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// requester ids and default bus widths.
package mem_arb_pkg;

    localparam int DEF_AW = 13;
    localparam int DEF_DW = 8;

    // Requester ids; the last-winner pointer uses the same encoding.
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // One-hot pulse vector {dma, cpu} for a requester id.
    function automatic logic [1:0] id_onehot(input logic id);
        logic [1:0] vec;
        if (id == ID_DMA) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: a lone requester wins; on a tie the requester
// that did not win last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_dma_i,
    input  logic last_i,
    output logic valid_o,
    output logic winner_o
);

    // Resolve the winner from the current requests and the last winner.
    always_comb begin
        valid_o  = req_cpu_i | req_dma_i;
        winner_o = ID_CPU;
        if (req_cpu_i && req_dma_i) begin
            winner_o = ~last_i;
        end else if (req_dma_i) begin
            winner_o = ID_DMA;
        end else begin
            winner_o = ID_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between a CPU and a DMA requester.
// One transfer at a time: IDLE samples requests, ACCESS drives the memory
// for WAIT_CYCLES cycles, RESP pulses the owner's done. All outputs are
// registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          cpu_done,
    output logic          dma_done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    arb_state_e    state_q;
    logic [3:0]    cnt_q;
    logic          id_q;
    logic          we_q;
    logic          last_q;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_read_q;
    logic          mem_write_q;

    logic          pick_valid_s;
    logic          pick_id_s;
    logic          req_we_s;
    logic [AW-1:0] req_addr_s;
    logic [DW-1:0] req_wdata_s;

    rr_pick2 u_pick (
        .req_cpu_i (cpu_req),
        .req_dma_i (dma_req),
        .last_i    (last_q),
        .valid_o   (pick_valid_s),
        .winner_o  (pick_id_s)
    );

    // Route the winning requester's transfer fields toward the latches.
    always_comb begin
        req_we_s    = cpu_we;
        req_addr_s  = cpu_addr;
        req_wdata_s = cpu_wdata;
        if (pick_id_s == ID_DMA) begin
            req_we_s    = dma_we;
            req_addr_s  = dma_addr;
            req_wdata_s = dma_wdata;
        end else begin
            req_we_s    = cpu_we;
            req_addr_s  = cpu_addr;
            req_wdata_s = cpu_wdata;
        end
    end

    // Transfer FSM with registered grants, dones, strobes and data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            id_q        <= ID_CPU;
            we_q        <= 1'b0;
            last_q      <= ID_DMA;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            rdata_q     <= {DW{1'b0}};
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_q     <= ST_ACCESS;
                        cnt_q       <= WAIT_LD;
                        id_q        <= pick_id_s;
                        last_q      <= pick_id_s;
                        we_q        <= req_we_s;
                        mem_addr_q  <= req_addr_s;
                        mem_wdata_q <= req_wdata_s;
                        mem_read_q  <= ~req_we_s;
                        mem_write_q <= req_we_s;
                        gnt_q       <= id_onehot(pick_id_s);
                    end else begin
                        state_q     <= ST_IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        // Last memory cycle: read data is valid now.
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        done_q      <= id_onehot(id_q);
                        state_q     <= ST_RESP;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt   = gnt_q[0];
    assign dma_gnt   = gnt_q[1];
    assign cpu_done  = done_q[0];
    assign dma_done  = done_q[1];
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 1 and 3), a
// transaction-level model tracking each transfer by its age in cycles,
// directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    cpu_req, dma_req, cpu_we, dma_we;
    logic [AW-1:0] cpu_addr [2];
    logic [AW-1:0] dma_addr [2];
    logic [DW-1:0] cpu_wdata [2];
    logic [DW-1:0] dma_wdata [2];
    logic [1:0]    cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write;
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic [AW-1:0] mem_addr [2];

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .dma_gnt(dma_gnt[0]), .cpu_done(cpu_done[0]), .dma_done(dma_done[0]),
        .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .dma_gnt(dma_gnt[1]), .cpu_done(cpu_done[1]), .dma_done(dma_done[1]),
        .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
    );

    // Memory contents as a pure function of address; 0x005 holds 0x3C.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 13'd37 + 13'd11;
        if (a == 13'h005) return 8'h3C;
        return t[7:0];
    endfunction

    function automatic int wk(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Arbitration rule: lone requester wins, tie goes to the non-last winner.
    function automatic logic pick(input logic c, input logic d, input logic last);
        if (c && d) return ~last;
        return d;
    endfunction

    // Model state per instance: age 0 = idle, 1..W = access cycles, W+1 = response.
    int            age [2];
    logic          own [2];
    logic          last_w [2];
    logic          we_m [2];
    logic [AW-1:0] addr_m [2];
    logic [DW-1:0] wd_m [2];
    logic [DW-1:0] rd_m [2];

    // The memory only presents valid data in the last access cycle.
    assign mem_rdata[0] = (age[0] == 1) ? rom(mem_addr[0]) : ~rom(mem_addr[0]);
    assign mem_rdata[1] = (age[1] == 3) ? rom(mem_addr[1]) : ~rom(mem_addr[1]);

    // Reference model advance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                age[k] <= 0; own[k] <= 1'b0; last_w[k] <= 1'b1; we_m[k] <= 1'b0;
                addr_m[k] <= '0; wd_m[k] <= '0; rd_m[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (age[k] == 0) begin
                    if (cpu_req[k] || dma_req[k]) begin
                        own[k]    <= pick(cpu_req[k], dma_req[k], last_w[k]);
                        last_w[k] <= pick(cpu_req[k], dma_req[k], last_w[k]);
                        we_m[k]   <= pick(cpu_req[k], dma_req[k], last_w[k]) ? dma_we[k] : cpu_we[k];
                        addr_m[k] <= pick(cpu_req[k], dma_req[k], last_w[k]) ? dma_addr[k] : cpu_addr[k];
                        wd_m[k]   <= pick(cpu_req[k], dma_req[k], last_w[k]) ? dma_wdata[k] : cpu_wdata[k];
                        age[k]    <= 1;
                    end
                end else if (age[k] == wk(k) + 1) begin
                    age[k] <= 0;
                end else begin
                    if (age[k] == wk(k) && !we_m[k]) rd_m[k] <= rom(addr_m[k]);
                    age[k] <= age[k] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [34:0] exp_v, act_v;
            logic        acc;
            acc   = (age[k] >= 1) && (age[k] <= wk(k));
            exp_v = {age[k] == 1 && !own[k], age[k] == 1 && own[k],
                     age[k] == wk(k) + 1 && !own[k], age[k] == wk(k) + 1 && own[k],
                     acc && !we_m[k], acc && we_m[k], addr_m[k], wd_m[k], rd_m[k]};
            act_v = {cpu_gnt[k], dma_gnt[k], cpu_done[k], dma_done[k],
                     mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k], rdata[k]};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_cmp w%0d t=%0t: got %h, expected %h", wk(k), $time, act_v, exp_v);
            end
            vectors++;
            if ((mem_read[k] & mem_write[k]) !== 1'b0) begin
                miscompares++;
                $display("FAIL strobe_excl w%0d t=%0t: got rd=%b wr=%b, expected not both", wk(k), $time, mem_read[k], mem_write[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 1'b0; dma_req[k] = 1'b0; cpu_we[k] = 1'b0; dma_we[k] = 1'b0;
            cpu_addr[k] = '0; dma_addr[k] = '0; cpu_wdata[k] = '0; dma_wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    int wr_cnt, gnt_at, done_at, cnt, done_seen;
    int g_who [$];
    int g_cyc [$];

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        chk("reset_rdata", rdata[1], 8'h00);
        chk("reset_addr", mem_addr[1], 13'h000);
        chk("reset_gnt", {cpu_gnt, dma_gnt}, 4'h0);
        rst = 1'b0;

        // CPU read at 0x005, single-cycle memory.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 13'h005;
        step();
        chk("t035_gnt", cpu_gnt[0], 1'b1);
        chk("t035_read", mem_read[0], 1'b1);
        chk("t035_addr", mem_addr[0], 13'h005);
        cpu_req[0] = 1'b0;
        step();
        chk("t035_done", cpu_done[0], 1'b1);
        chk("t035_read_off", mem_read[0], 1'b0);
        chk("t035_rdata", rdata[0], 8'h3C);

        // DMA write of 0xA5 to 0x1FF, three-cycle memory.
        dma_req[1] = 1'b1; dma_we[1] = 1'b1; dma_addr[1] = 13'h1FF; dma_wdata[1] = 8'hA5;
        wr_cnt = 0; gnt_at = -1; done_at = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (dma_gnt[1] && gnt_at < 0) begin gnt_at = c; dma_req[1] = 1'b0; end
            if (mem_write[1]) begin
                wr_cnt++;
                chk("t036_waddr", mem_addr[1], 13'h1FF);
            end
            if (dma_done[1] && done_at < 0) done_at = c;
        end
        chk("t036_gnt_at", gnt_at, 1);
        chk("t036_wr_cycles", wr_cnt, 3);
        chk("t036_done_at", done_at, 4);
        chk("t036_wdata", mem_wdata[1], 8'hA5);
        chk("t036_rdata_kept", rdata[1], 8'h00);

        // Both requesters held from reset: alternating grants, 5 cycles apart.
        do_reset();
        cpu_req[1] = 1'b1; cpu_addr[1] = 13'h010;
        dma_req[1] = 1'b1; dma_addr[1] = 13'h020;
        g_who.delete(); g_cyc.delete();
        for (int c = 1; c <= 24; c++) begin
            step();
            if (cpu_gnt[1]) begin g_who.push_back(0); g_cyc.push_back(c); end
            if (dma_gnt[1]) begin g_who.push_back(1); g_cyc.push_back(c); end
        end
        chk("t037_count", (g_who.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < g_who.size(); i++) begin
            chk($sformatf("t037_who%0d", i), g_who[i], i % 2);
            chk($sformatf("t037_cyc%0d", i), g_cyc[i], 1 + 5 * i);
        end

        // Reset in the second access cycle of a three-cycle read.
        do_reset();
        cpu_req[1] = 1'b1; cpu_addr[1] = 13'h033;
        step();
        chk("t038_gnt", cpu_gnt[1], 1'b1);
        cpu_req[1] = 1'b0;
        step();
        chk("t038_read_before", mem_read[1], 1'b1);
        rst = 1'b1;
        #1;
        chk("t038_read_abort", mem_read[1], 1'b0);
        done_seen = 0;
        step();
        done_seen += cpu_done[1] + dma_done[1];
        rst = 1'b0;
        cpu_req[1] = 1'b1; dma_req[1] = 1'b1;
        done_seen += cpu_done[1] + dma_done[1];
        step();
        chk("t038_tie_cpu", cpu_gnt[1], 1'b1);
        chk("t038_tie_dma", dma_gnt[1], 1'b0);
        chk("t038_no_done", done_seen, 0);
        cpu_req[1] = 1'b0; dma_req[1] = 1'b0;
        repeat (5) step();

        // DMA request only while the CPU transfer is in ACCESS.
        do_reset();
        cpu_req[1] = 1'b1; cpu_addr[1] = 13'h044;
        step();
        cnt = 0; done_seen = 0;
        cpu_req[1] = 1'b0; dma_req[1] = 1'b1;
        step(); cnt += dma_gnt[1];
        step(); cnt += dma_gnt[1];
        step(); cnt += dma_gnt[1]; done_seen += cpu_done[1];
        dma_req[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            cnt += dma_gnt[1];
        end
        chk("t039_cpu_done", done_seen, 1);
        chk("t039_no_dma_gnt", cnt, 0);

        // Random traffic on both instances.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            step();
            if ($urandom_range(1999) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (cpu_req[k] && age[k] == 1 && !own[k]) begin
                    if ($urandom_range(9) < 7) cpu_req[k] = 1'b0;
                    else begin cpu_we[k] = 1'($urandom); cpu_addr[k] = AW'($urandom); cpu_wdata[k] = DW'($urandom); end
                end else if (!cpu_req[k]) begin
                    if ($urandom_range(9) < 3) begin
                        cpu_req[k] = 1'b1; cpu_we[k] = 1'($urandom);
                        cpu_addr[k] = AW'($urandom); cpu_wdata[k] = DW'($urandom);
                    end
                end else if ($urandom_range(49) == 0) begin
                    cpu_req[k] = 1'b0;
                end
                if (dma_req[k] && age[k] == 1 && own[k]) begin
                    if ($urandom_range(9) < 7) dma_req[k] = 1'b0;
                    else begin dma_we[k] = 1'($urandom); dma_addr[k] = AW'($urandom); dma_wdata[k] = DW'($urandom); end
                end else if (!dma_req[k]) begin
                    if ($urandom_range(9) < 3) begin
                        dma_req[k] = 1'b1; dma_we[k] = 1'($urandom);
                        dma_addr[k] = AW'($urandom); dma_wdata[k] = DW'($urandom);
                    end
                end else if ($urandom_range(49) == 0) begin
                    dma_req[k] = 1'b0;
                end
            end
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
